ldpc_llr_frame_packer: RTL and testbench

//  Upstream feeder of LDPC_decode_top. Takes a narrow LLR stream, one codeword per S_LAST-terminated packet.

---
 rtl/ldpc_llr_frame_packer_pkg.sv | 26 ++
 rtl/ldpc_llr_frame_packer_sat.sv | 26 ++
 rtl/ldpc_llr_frame_packer.sv | 183 ++++++++++++++++++
 tb/tb_ldpc_llr_frame_packer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_llr_frame_packer_pkg.sv
// Shared constants, mode encodings and FSM state type for the LDPC LLR frame packer.
package ldpc_pkg;
  localparam int ZC        = 512;
  localparam int VWIDTH    = 6;
  localparam int IN_W      = 8;
  localparam int LANES     = 64;
  localparam int BEATS     = ZC / LANES;
  localparam int BEAT_BITS = LANES * VWIDTH;

  localparam logic [1:0] MODE_R23 = 2'd1;
  localparam logic [1:0] MODE_R78 = 2'd2;
  localparam int WORDS_R23 = 32;
  localparam int WORDS_R78 = 24;
  localparam int LLR_MAX   = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_DROP
  } state_e;

  function automatic logic mode_legal(input logic [1:0] m);
    return (m == MODE_R23) || (m == MODE_R78);
  endfunction
endpackage

// File: rtl/ldpc_llr_frame_packer_sat.sv
// Symmetric signed clamp of one LLR from IW to OW bits; the most negative OW code is never produced.
module llr_sat
  import ldpc_pkg::*;
#(
  parameter int IW = IN_W,
  parameter int OW = VWIDTH
) (
  input  logic signed [IW-1:0] llr_in,
  output logic signed [OW-1:0] llr_out
);
  localparam int LIM = (1 << (OW - 1)) - 1;
  localparam logic signed [IW-1:0] POS_I = IW'(LIM);
  localparam logic signed [IW-1:0] NEG_I = IW'(-LIM);
  localparam logic signed [OW-1:0] POS_O = OW'(LIM);
  localparam logic signed [OW-1:0] NEG_O = OW'(-LIM);

  always_comb begin
    if (llr_in > POS_I) begin
      llr_out = POS_O;
    end else if (llr_in < NEG_I) begin
      llr_out = NEG_O;
    end else begin
      llr_out = llr_in[OW-1:0];
    end
  end
endmodule

// File: rtl/ldpc_llr_frame_packer.sv
// Packs a narrow saturated LLR stream into ZC-wide decoder words, repairing short/long codewords.
module ldpc_llr_frame_packer
  import ldpc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic                     S_VALID,
  output logic                     S_READY,
  input  logic                     S_LAST,
  input  logic [LANES*IN_W-1:0]    S_DATA,
  output logic                     W_VALID,
  input  logic                     W_READY,
  output logic                     W_LAST,
  output logic [ZC*VWIDTH-1:0]     W_DATA,
  output logic                     err_mode,
  output logic                     err_len,
  output logic                     busy
);
  localparam int WW     = ZC * VWIDTH;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int WCNT_W = $clog2(WORDS_R23);

  state_e              state_q, state_d;
  logic [1:0]          mode_r_q, mode_r_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [WW-1:0]       asm_q, asm_d, out_q, out_d;
  logic                asm_full_q, asm_full_d, asm_last_q, asm_last_d;
  logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                err_mode_q, err_mode_d, err_len_q, err_len_d;

  logic [BEAT_BITS-1:0] sat_beat;
  logic [WW-1:0]        word_fill;
  logic [WCNT_W-1:0]    wmax_m1;
  logic                 accept, out_free, final_beat, last_word, word_done, pad_word;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_sat
    llr_sat #(.IW(IN_W), .OW(VWIDTH)) u_sat (
      .llr_in  (S_DATA[gi*IN_W +: IN_W]),
      .llr_out (sat_beat[gi*VWIDTH +: VWIDTH])
    );
  end

  assign S_READY = ((state_q == ST_FILL) || (state_q == ST_DROP)) && !asm_full_q;
  assign accept  = S_VALID && S_READY;
  // The output slot is free if empty or being drained this cycle; never looks at W_VALID combinationally.
  assign out_free   = !out_valid_q || W_READY;
  assign wmax_m1    = (mode_r_q == MODE_R78) ? WCNT_W'(WORDS_R78 - 1) : WCNT_W'(WORDS_R23 - 1);
  assign final_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign last_word  = (wcnt_q == wmax_m1);

  always_comb begin
    // Starting a new word clears asm, so lanes after an early S_LAST read as zero.
    word_fill = (beat_q == '0) ? '0 : asm_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == BEAT_W'(k)) word_fill[k*BEAT_BITS +: BEAT_BITS] = sat_beat;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_r_d    = mode_r_q;
    beat_d      = beat_q;
    wcnt_d      = wcnt_q;
    asm_d       = asm_q;
    asm_full_d  = asm_full_q;
    asm_last_d  = asm_last_q;
    out_d       = out_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !W_READY;
    err_mode_d  = err_mode_q;
    err_len_d   = 1'b0;
    word_done   = 1'b0;
    pad_word    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (S_VALID) begin
          if (mode_legal(mode)) begin
            state_d    = ST_FILL;
            mode_r_d   = mode;
            err_mode_d = 1'b0;
            beat_d     = '0;
            wcnt_d     = '0;
          end else begin
            err_mode_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (asm_full_q && asm_last_q && out_free) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          asm_d = word_fill;
          if (final_beat || S_LAST) begin
            word_done = 1'b1;
            beat_d    = '0;
            err_len_d = S_LAST != (final_beat && last_word);
            if (!last_word) begin
              if (S_LAST) state_d = ST_PAD;
            end else if (!S_LAST) begin
              state_d = ST_DROP;
            end else if (out_free) begin
              state_d = ST_IDLE;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_PAD: begin
        if (asm_full_q) begin
          if (asm_last_q && out_free) state_d = ST_IDLE;
        end else begin
          word_done = 1'b1;
          pad_word  = 1'b1;
          if (last_word && out_free) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (accept && S_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A finished word goes straight to out when the slot is free, otherwise it waits in asm.
    if (word_done) begin
      wcnt_d = wcnt_q + WCNT_W'(1);
      if (out_free) begin
        out_d       = pad_word ? '0 : word_fill;
        out_last_d  = last_word;
        out_valid_d = 1'b1;
      end else begin
        asm_d      = pad_word ? '0 : word_fill;
        asm_full_d = 1'b1;
        asm_last_d = last_word;
      end
    end else if (asm_full_q && out_free) begin
      out_d       = asm_q;
      out_last_d  = asm_last_q;
      out_valid_d = 1'b1;
      asm_full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_r_q    <= '0;
      beat_q      <= '0;
      wcnt_q      <= '0;
      asm_q       <= '0;
      asm_full_q  <= 1'b0;
      asm_last_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_mode_q  <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_r_q    <= mode_r_d;
      beat_q      <= beat_d;
      wcnt_q      <= wcnt_d;
      asm_q       <= asm_d;
      asm_full_q  <= asm_full_d;
      asm_last_q  <= asm_last_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_mode_q  <= err_mode_d;
      err_len_q   <= err_len_d;
    end
  end

  assign W_VALID  = out_valid_q;
  assign W_LAST   = out_last_q;
  assign W_DATA   = out_q;
  assign err_mode = err_mode_q;
  assign err_len  = err_len_q;
  assign busy     = (state_q != ST_IDLE) || asm_full_q || out_valid_q;
endmodule

// File: tb/tb_ldpc_llr_frame_packer.sv
// Directed bench for the LLR frame packer: frames are driven beat by beat and every output word is compared to a reference.
`timescale 1ns/1ps
module tb_ldpc_llr_frame_packer;
  localparam int LANES = 64;
  localparam int IN_W  = 8;
  localparam int VW    = 6;
  localparam int ZC    = 512;
  localparam int BEATS = 8;
  localparam int WW    = ZC * VW;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [1:0]            mode = 2'd0;
  logic                  S_VALID = 1'b0;
  logic                  S_LAST = 1'b0;
  logic [LANES*IN_W-1:0] S_DATA = '0;
  logic                  W_READY = 1'b1;
  logic                  S_READY, W_VALID, W_LAST, err_mode, err_len, busy;
  logic [WW-1:0]         W_DATA;

  int n_checks = 0;
  int n_errors = 0;

  int wr_pol = 0;
  int stall_left = 0;
  int beats_acc = 0;
  int acc_at_stall = -1;
  logic [WW-1:0] first_word;

  always #5 clk = ~clk;

  ldpc_llr_frame_packer dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_LAST(S_LAST), .S_DATA(S_DATA),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_LAST(W_LAST), .W_DATA(W_DATA),
    .err_mode(err_mode), .err_len(err_len), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pat_val(input int pat, input int g, input int j);
    int tbl[7] = '{-128, -32, -31, 0, 31, 32, 127};
    case (pat)
      0: return j;
      1: return ((g * 7 + j * 3 + 5) % 256) - 128;
      default: return tbl[(j + g) % 7];
    endcase
  endfunction

  function automatic int sat(input int x);
    if (x < -31) return -31;
    if (x > 31) return 31;
    return x;
  endfunction

  function automatic logic [VW-1:0] exp_field(input int n, input int pat, input int w, input int f);
    int g = w * BEATS + f / LANES;
    if (g >= n) return '0;
    return VW'(sat(pat_val(pat, g, f % LANES)));
  endfunction

  function automatic logic [LANES*IN_W-1:0] beat_data(input int pat, input int g);
    logic [LANES*IN_W-1:0] d;
    for (int j = 0; j < LANES; j++) d[j*IN_W +: IN_W] = IN_W'(pat_val(pat, g, j));
    return d;
  endfunction

  // Output collector: records every accepted word, err_len pulses and any change while stalled.
  logic [WW-1:0] wq[$];
  bit            lq[$];
  int            stab_err = 0;
  int            errlen_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!W_VALID || W_DATA !== prev_data || W_LAST !== prev_last)) stab_err++;
      if (W_VALID && W_READY) begin
        wq.push_back(W_DATA);
        lq.push_back(W_LAST);
      end
      if (err_len) errlen_cnt++;
      prev_stall = W_VALID && !W_READY;
      prev_data  = W_DATA;
      prev_last  = W_LAST;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_pol == 1) W_READY = !W_READY;
    else W_READY = 1'b1;
    if (stall_left > 0) begin
      stall_left--;
      W_READY = 1'b0;
      if (stall_left == 0) acc_at_stall = beats_acc;
    end
  endtask

  task automatic send_frame(input logic [1:0] m, input int n, input int pat, input int stop_at);
    int   b = 0;
    int   guard = 0;
    logic acc;
    mode = m;
    while (b < n && b != stop_at && guard < 4000) begin
      S_VALID = 1'b1;
      S_LAST  = (b == n - 1);
      S_DATA  = beat_data(pat, b);
      @(negedge clk);
      acc = S_READY;
      if (acc) b++;
      beats_acc = b;
      guard++;
      tick();
    end
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
    if (guard >= 4000) check("send_timeout", 64'(b), 64'(n));
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while ((busy || W_VALID) && guard < 2000) begin
      tick();
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("drain_timeout", 64'(busy), 64'd0);
    tick();
  endtask

  task automatic run_frame(input string tag, input logic [1:0] m, input int n, input int pat,
                           input int wmax, input int pol, input int stall, input int exp_errlen);
    int            el0 = errlen_cnt;
    int            st0 = stab_err;
    int            idx;
    logic [WW-1:0] word;
    bit            last;
    wr_pol     = pol;
    stall_left = stall;
    send_frame(m, n, pat, -1);
    wait_idle();
    wr_pol = 0;
    for (int w = 0; w < wmax; w++) begin
      if (wq.size() == 0) begin
        check($sformatf("%s words_received", tag), 64'(w), 64'(wmax));
        break;
      end
      word = wq.pop_front();
      last = lq.pop_front();
      if (w == 0) first_word = word;
      idx = 0;
      for (int f = 0; f < ZC; f++) begin
        if (word[f*VW +: VW] !== exp_field(n, pat, w, f)) begin
          idx = f;
          break;
        end
      end
      check($sformatf("%s w%0d last", tag, w), 64'(last), 64'(w == wmax - 1));
      check($sformatf("%s w%0d field%0d", tag, w, idx), 64'(word[idx*VW +: VW]), 64'(exp_field(n, pat, w, idx)));
      $display("%s word %0d last=%0d field0=%0h", tag, w, last, word[VW-1:0]);
    end
    check($sformatf("%s extra_words", tag), 64'(wq.size()), 64'd0);
    check($sformatf("%s err_len_pulses", tag), 64'(errlen_cnt - el0), 64'(exp_errlen));
    check($sformatf("%s stall_stability", tag), 64'(stab_err - st0), 64'd0);
    check($sformatf("%s err_mode", tag), 64'(err_mode), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] hand[7];
    hand = '{6'h21, 6'h21, 6'h21, 6'h00, 6'h1F, 6'h1F, 6'h1F};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst W_VALID", 64'(W_VALID), 64'd0);
    check("rst W_LAST", 64'(W_LAST), 64'd0);
    check("rst W_DATA_any", 64'(|W_DATA), 64'd0);
    check("rst S_READY", 64'(S_READY), 64'd0);
    check("rst err_mode", 64'(err_mode), 64'd0);
    check("rst err_len", 64'(err_len), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    run_frame("r23_ramp", 2'd1, 256, 0, 32, 0, 0, 0);
    run_frame("r78_toggle", 2'd2, 192, 1, 24, 1, 0, 0);

    acc_at_stall = -1;
    run_frame("r23_stall", 2'd1, 256, 1, 32, 0, 40, 0);
    check("stall beats_before_release", 64'(acc_at_stall), 64'd16);

    run_frame("r23_bounds", 2'd1, 256, 2, 32, 0, 0, 0);
    for (int j = 0; j < 7; j++)
      check($sformatf("bounds lane%0d", j), 64'(first_word[j*VW +: VW]), 64'(hand[j]));

    run_frame("r23_short", 2'd1, 100, 1, 32, 0, 0, 1);
    run_frame("r23_long", 2'd1, 260, 1, 32, 0, 0, 1);
    run_frame("r78_after_long", 2'd2, 192, 0, 24, 0, 0, 0);

    mode = 2'd3;
    S_VALID = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("mode3 err_mode", 64'(err_mode), 64'd1);
    check("mode3 S_READY", 64'(S_READY), 64'd0);
    check("mode3 busy", 64'(busy), 64'd0);
    S_VALID = 1'b0;
    tick();
    @(negedge clk);
    check("mode3 err_mode_held", 64'(err_mode), 64'd1);
    tick();

    send_frame(2'd1, 256, 1, 50);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst W_VALID", 64'(W_VALID), 64'd0);
    check("midrst W_DATA_any", 64'(|W_DATA), 64'd0);
    check("midrst S_READY", 64'(S_READY), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst err_mode", 64'(err_mode), 64'd0);
    wq.delete();
    lq.delete();
    tick();
    rst_n = 1'b1;
    tick();
    run_frame("r23_after_rst", 2'd1, 256, 2, 32, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
